// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives start/a/b; the slave returns busy/done/diff/borrow_out.
interface serial_subtractor_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
   );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SAT_EN: clamp diff to 0 on final borrow.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input logic                     clk,
   input logic                     rst,
   serial_subtractor_ctrl_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] dsh_q, dsh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;

   logic             load;
   logic             last;
   logic             hs1_d, hs1_b;
   logic             hs2_d, hs2_b;
   logic             br_nxt;
   logic [WIDTH-1:0] dsh_nxt;
   logic [WIDTH-1:0] res;

   assign load = bus.start && (state_q == IDLE || state_q == DONE);
   assign last = (cnt_q == CW'(WIDTH - 1));

   // Shared cell: two half-subtractors, borrows merged by an OR
   assign hs1_d  = a_q[0] ^ b_q[0];
   assign hs1_b  = ~a_q[0] & b_q[0];
   assign hs2_d  = hs1_d ^ br_q;
   assign hs2_b  = ~hs1_d & br_q;
   assign br_nxt = hs1_b | hs2_b;

   // Difference bit enters from the MSB side
   always_comb begin
      dsh_nxt            = dsh_q >> 1;
      dsh_nxt[WIDTH-1]   = hs2_d;
   end

   // Final result, optionally clamped on underflow
   always_comb begin
`ifdef SERIAL_SUB_SAT_EN
      res = br_nxt ? '0 : dsh_nxt;
`else
      res = dsh_nxt;
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state and result registers
   always_comb begin
      bus.busy       = (state_q == RUN);
      bus.done       = (state_q == DONE);
      bus.diff       = diff_q;
      bus.borrow_out = bout_q;
   end

   // Datapath next-state: load, shift one bit, or hold
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      dsh_d  = dsh_q;
      diff_d = diff_q;
      cnt_d  = cnt_q;
      br_d   = br_q;
      bout_d = bout_q;
      if (load) begin
         a_d   = bus.a;
         b_d   = bus.b;
         dsh_d = '0;
         cnt_d = '0;
         br_d  = 1'b0;
      end else if (state_q == RUN) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         dsh_d = dsh_nxt;
         br_d  = br_nxt;
         cnt_d = cnt_q + 1'b1;
         if (last) begin
            diff_d = res;
            bout_d = br_nxt;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         dsh_q  <= '0;
         diff_q <= '0;
         cnt_q  <= '0;
         br_q   <= 1'b0;
         bout_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         dsh_q  <= dsh_d;
         diff_q <= diff_d;
         cnt_q  <= cnt_d;
         br_q   <= br_d;
         bout_q <= bout_d;
      end
   end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl, WIDTH=8 and WIDTH=1.
// Results are checked against a scoreboard filled at each accepted start.
module tb_serial_subtractor_ctrl;
   logic clk;
   logic rst;

   serial_subtractor_ctrl_if #(.WIDTH(8)) if8 ();
   serial_subtractor_ctrl_if #(.WIDTH(1)) if1 ();

   serial_subtractor_ctrl #(.WIDTH(8)) u8 (
      .clk (clk),
      .rst (rst),
      .bus (if8.slave)
   );

   serial_subtractor_ctrl #(.WIDTH(1)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   int errs   = 0;
   int checks = 0;
   int done8  = 0;
   int done1  = 0;

   logic [8:0] q8[$];
   logic [1:0] q1[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] exp8(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] d;
      logic       br;
      d  = a - b;
      br = (a < b);
`ifdef SERIAL_SUB_SAT_EN
      if (br) d = '0;
`endif
      return {br, d};
   endfunction

   function automatic logic [1:0] exp1(input logic a, input logic b);
      logic d;
      logic br;
      d  = a ^ b;
      br = ~a & b;
`ifdef SERIAL_SUB_SAT_EN
      if (br) d = 1'b0;
`endif
      return {br, d};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done8(input string tag);
      int n = 0;
      while (!if8.done && n < 40) begin
         tick();
         n++;
      end
      chk(tag, if8.done, 1);
   endtask

   // Scoreboard consumers, sampled 1 time unit after each rising edge
   always @(posedge clk) begin
      logic [8:0] e8;
      logic [1:0] e1;
      #1;
      if (if8.done) begin
         done8++;
         chk("u8_busy_with_done", if8.busy, 0);
         if (q8.size() == 0) begin
            chk("u8_unexpected_done", 1, 0);
         end else begin
            e8 = q8.pop_front();
            chk("u8_diff", if8.diff, e8[7:0]);
            chk("u8_borrow", if8.borrow_out, e8[8]);
         end
      end
      if (if1.done) begin
         done1++;
         if (q1.size() == 0) begin
            chk("u1_unexpected_done", 1, 0);
         end else begin
            e1 = q1.pop_front();
            chk("u1_diff", if1.diff, e1[0]);
            chk("u1_borrow", if1.borrow_out, e1[1]);
         end
      end
   end

   initial begin
      int bc;
      int n;
      int d0;

      rst       = 1'b1;
      if8.start = 1'b0;
      if8.a     = '0;
      if8.b     = '0;
      if1.start = 1'b0;
      if1.a     = '0;
      if1.b     = '0;
      tick(2);
      rst = 1'b0;
      tick();
      chk("rst_busy", if8.busy, 0);
      chk("rst_done", if8.done, 0);
      chk("rst_diff", if8.diff, 0);
      chk("rst_borrow", if8.borrow_out, 0);

      // Basic subtract and busy length
      if8.a = 8'd200; if8.b = 8'd55; if8.start = 1'b1;
      q8.push_back(exp8(8'd200, 8'd55));
      tick();
      if8.start = 1'b0;
      bc = 0;
      while (if8.busy && bc < 20) begin
         bc++;
         tick();
      end
      chk("busy_cycles", bc, 8);
      chk("done_after_run", if8.done, 1);
      tick();
      chk("done_one_cycle", if8.done, 0);

      // Underflow; old result held during RUN
      if8.a = 8'd5; if8.b = 8'd10; if8.start = 1'b1;
      q8.push_back(exp8(8'd5, 8'd10));
      tick();
      if8.start = 1'b0;
      tick(3);
      chk("diff_held_in_run", if8.diff, 145);
      wait_done8("underflow_done");
      tick();

      // Start while busy is ignored
      d0 = done8;
      if8.a = 8'd200; if8.b = 8'd55; if8.start = 1'b1;
      q8.push_back(exp8(8'd200, 8'd55));
      tick();
      if8.start = 1'b0;
      tick(2);
      if8.a = 8'd1; if8.b = 8'd1; if8.start = 1'b1;
      tick();
      if8.start = 1'b0;
      wait_done8("busy_start_done");
      tick(4);
      chk("busy_start_one_done", done8 - d0, 1);

      // Back-to-back with start held
      if8.a = 8'd9; if8.b = 8'd3; if8.start = 1'b1;
      q8.push_back(exp8(8'd9, 8'd3));
      tick();
      if8.a = 8'd0; if8.b = 8'd1;
      q8.push_back(exp8(8'd0, 8'd1));
      wait_done8("b2b_first_done");
      tick();
      n = 1;
      while (!if8.done && n < 20) begin
         tick();
         n++;
      end
      chk("b2b_spacing", n, 9);
      if8.start = 1'b0;
      tick();
      chk("b2b_stop_done", if8.done, 0);
      chk("b2b_stop_busy", if8.busy, 0);

      // Reset mid-run aborts the job
      d0 = done8;
      if8.a = 8'd200; if8.b = 8'd55; if8.start = 1'b1;
      tick();
      if8.start = 1'b0;
      tick(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", if8.busy, 0);
      chk("abort_done", if8.done, 0);
      chk("abort_diff", if8.diff, 0);
      chk("abort_borrow", if8.borrow_out, 0);
      tick(12);
      chk("abort_no_done", done8 - d0, 0);

      // Reset and start together: start dropped
      rst = 1'b1; if8.start = 1'b1;
      tick();
      rst = 1'b0; if8.start = 1'b0;
      chk("rst_start_busy", if8.busy, 0);
      tick(2);
      chk("rst_start_idle", if8.busy, 0);

      // Fresh job after reset
      if8.a = 8'd100; if8.b = 8'd30; if8.start = 1'b1;
      q8.push_back(exp8(8'd100, 8'd30));
      tick();
      if8.start = 1'b0;
      wait_done8("post_rst_done");
      tick();

      // Edge values
      if8.a = 8'd255; if8.b = 8'd255; if8.start = 1'b1;
      q8.push_back(exp8(8'd255, 8'd255));
      tick();
      if8.start = 1'b0;
      wait_done8("eq_done");
      tick();
      if8.a = 8'd0; if8.b = 8'd255; if8.start = 1'b1;
      q8.push_back(exp8(8'd0, 8'd255));
      tick();
      if8.start = 1'b0;
      wait_done8("min_max_done");
      tick();

      // WIDTH=1: 0 - 1
      if1.a = 1'b0; if1.b = 1'b1; if1.start = 1'b1;
      q1.push_back(exp1(1'b0, 1'b1));
      tick();
      if1.start = 1'b0;
      chk("w1_busy", if1.busy, 1);
      tick();
      chk("w1_done", if1.done, 1);
      tick();
      chk("w1_done_pulse", if1.done, 0);
      tick(2);

      chk("q8_drained", q8.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("w1_done_count", done1, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
